// File: rtl/shape_rasterizer.sv
// Rasterizes a latched pixel rectangle (filled, 1-pixel border or inscribed circle) into
// framebuffer writes in row-major order; each covered pixel holds print_enable for WR_HOLD cycles.
module shape_rasterizer #(
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int COLOR_BITS = 3,
  parameter int WR_HOLD    = 3
) (
  input  logic                     Clck,
  input  logic                     Reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               mode,
  input  logic [X_BITS-1:0]        x_start,
  input  logic [X_BITS-1:0]        x_end,
  input  logic [Y_BITS-1:0]        y_start,
  input  logic [Y_BITS-1:0]        y_end,
  input  logic [COLOR_BITS-1:0]    color,
  output logic [X_BITS-1:0]        paint_x_co,
  output logic [Y_BITS-1:0]        paint_y_co,
  output logic [COLOR_BITS-1:0]    color_output,
  output logic                     print_enable,
  output logic                     busy,
  output logic                     done,
  output logic [X_BITS+Y_BITS-1:0] written_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EVAL  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_ADV   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam int DW = X_BITS + 2;
  localparam int PW = 2 * DW;
  localparam int SW = PW + 1;
  localparam int HW = $clog2(WR_HOLD + 1);
  localparam int CW = X_BITS + Y_BITS;

  logic [2:0]            state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [X_BITS-1:0]     xs_q, xs_d, xe_q, xe_d, x_q, x_d, px_q, px_d;
  logic [Y_BITS-1:0]     ys_q, ys_d, ye_q, ye_d, y_q, y_d, py_q, py_d;
  logic [COLOR_BITS-1:0] col_q, col_d, pc_q, pc_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [DW-1:0] w, h, dx, dy, adx, ady, m;
  logic [PW-1:0] dx2, dy2, m2;
  logic [SW-1:0] dist2;
  logic          last_x, last_y, cov_border, cov_circle, covered;

  // Centre offsets are doubled so the circle test stays in integers for even and odd sizes.
  always_comb begin
    w   = DW'(xe_q) - DW'(xs_q);
    h   = DW'(ye_q) - DW'(ys_q);
    dx  = ((DW'(x_q) - DW'(xs_q)) << 1) + DW'(1) - w;
    dy  = ((DW'(y_q) - DW'(ys_q)) << 1) + DW'(1) - h;
    adx = dx[DW-1] ? (~dx + DW'(1)) : dx;
    ady = dy[DW-1] ? (~dy + DW'(1)) : dy;
    m   = (w < h) ? w : h;
  end

  assign dx2        = PW'(adx) * PW'(adx);
  assign dy2        = PW'(ady) * PW'(ady);
  assign m2         = PW'(m) * PW'(m);
  assign dist2      = SW'(dx2) + SW'(dy2);
  assign last_x     = (x_q == xe_q - X_BITS'(1));
  assign last_y     = (y_q == ye_q - Y_BITS'(1));
  assign cov_border = (x_q == xs_q) || last_x || (y_q == ys_q) || last_y;
  assign cov_circle = (dist2 <= SW'(m2));

  always_comb begin
    case (mode_q)
      2'b01:   covered = cov_border;
      2'b10:   covered = cov_circle;
      default: covered = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    ys_d    = ys_q;
    ye_d    = ye_q;
    col_d   = col_q;
    x_d     = x_q;
    y_d     = y_q;
    px_d    = px_q;
    py_d    = py_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_d  = mode;
            xs_d    = x_start;
            xe_d    = x_end;
            ys_d    = y_start;
            ye_d    = y_end;
            col_d   = color;
            x_d     = x_start;
            y_d     = y_start;
            cnt_d   = '0;
            state_d = ((x_end <= x_start) || (y_end <= y_start)) ? S_DONE : S_EVAL;
          end
        end
        S_EVAL: begin
          if (covered) begin
            px_d    = x_q;
            py_d    = y_q;
            pc_d    = col_q;
            state_d = S_LOAD;
          end else begin
            state_d = S_ADV;
          end
        end
        S_LOAD: begin
          hold_d  = '0;
          cnt_d   = cnt_q + CW'(1);
          state_d = S_WRITE;
        end
        S_WRITE: begin
          if (hold_q == HW'(WR_HOLD - 1)) state_d = S_GAP;
          else                            hold_d  = hold_q + HW'(1);
        end
        S_GAP: state_d = S_ADV;
        S_ADV: begin
          if (last_x && last_y) begin
            state_d = S_DONE;
          end else if (last_x) begin
            x_d     = xs_q;
            y_d     = y_q + Y_BITS'(1);
            state_d = S_EVAL;
          end else begin
            x_d     = x_q + X_BITS'(1);
            state_d = S_EVAL;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clck) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      xs_q    <= '0;
      xe_q    <= '0;
      ys_q    <= '0;
      ye_q    <= '0;
      col_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pc_q    <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      ys_q    <= ys_d;
      ye_q    <= ye_d;
      col_q   <= col_d;
      x_q     <= x_d;
      y_q     <= y_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  assign paint_x_co    = px_q;
  assign paint_y_co    = py_q;
  assign color_output  = pc_q;
  assign print_enable  = (state_q == S_WRITE);
  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign written_count = cnt_q;

endmodule

// File: tb/tb_shape_rasterizer.sv
// Randomized and directed bench for shape_rasterizer against a per-pixel coverage model.
module tb_shape_rasterizer;
  localparam int XB = 8;
  localparam int YB = 7;
  localparam int CB = 3;
  localparam int H  = 3;

  logic          Clck = 1'b0;
  logic          Reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode = '0;
  logic [XB-1:0] x_start = '0, x_end = '0;
  logic [YB-1:0] y_start = '0, y_end = '0;
  logic [CB-1:0] color = '0;
  logic [XB-1:0] paint_x_co;
  logic [YB-1:0] paint_y_co;
  logic [CB-1:0] color_output;
  logic          print_enable, busy, done;
  logic [XB+YB-1:0] written_count;

  shape_rasterizer #(.X_BITS(XB), .Y_BITS(YB), .COLOR_BITS(CB), .WR_HOLD(H)) dut (
    .Clck(Clck), .Reset(Reset), .start(start), .abort(abort), .mode(mode),
    .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end), .color(color),
    .paint_x_co(paint_x_co), .paint_y_co(paint_y_co), .color_output(color_output),
    .print_enable(print_enable), .busy(busy), .done(done), .written_count(written_count)
  );

  always #5 Clck = ~Clck;

  int vectors = 0;
  int miscompares = 0;
  int obs_x[$], obs_y[$], obs_c[$], obs_len[$];
  int obs_lat, obs_done_w, obs_busy_bad, obs_stable_bad, obs_cnt, obs_timeout;
  int ab_pe, ab_busy, ab_done, ab_cnt;
  int exp_x[$], exp_y[$];
  int exp_lat;
  bit glitch = 1'b0;

  function automatic bit covered(int md, int xs, int xe, int ys, int ye, int x, int y);
    int w, h, dx, dy, m;
    w  = xe - xs;
    h  = ye - ys;
    dx = 2 * (x - xs) + 1 - w;
    dy = 2 * (y - ys) + 1 - h;
    m  = (w < h) ? w : h;
    case (md)
      1:       return (x == xs) || (x == xe - 1) || (y == ys) || (y == ye - 1);
      2:       return (dx * dx + dy * dy) <= (m * m);
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_job(input int md, input int xs, input int xe, input int ys, input int ye);
    exp_x.delete();
    exp_y.delete();
    exp_lat = 0;
    if (xe <= xs || ye <= ys) return;
    for (int y = ys; y < ye; y++) begin
      for (int x = xs; x < xe; x++) begin
        if (covered(md, xs, xe, ys, ye, x, y)) begin
          exp_x.push_back(x);
          exp_y.push_back(y);
          exp_lat += H + 4;
        end else begin
          exp_lat += 2;
        end
      end
    end
  endtask

  // Drives one job and records what the write port does; cycle 0 is the first cycle after the accept edge.
  task automatic exec_job(input int md, input int xs, input int xe, input int ys, input int ye,
                          input int col, input int abort_wr);
    int  cyc, run, cx, cy, aborted_at;
    bit  prev_pe;
    obs_x.delete(); obs_y.delete(); obs_c.delete(); obs_len.delete();
    obs_lat = -1; obs_done_w = 0; obs_busy_bad = 0; obs_stable_bad = 0;
    ab_pe = -1; ab_busy = -1; ab_done = -1; ab_cnt = -1;
    run = 0; cx = 0; cy = 0; prev_pe = 1'b0; aborted_at = -1;
    @(negedge Clck);
    mode = 2'(md); x_start = XB'(xs); x_end = XB'(xe); y_start = YB'(ys); y_end = YB'(ye);
    color = CB'(col); start = 1'b1;
    @(posedge Clck);
    for (cyc = 0; cyc < 4000; cyc++) begin
      @(negedge Clck);
      start = 1'b0;
      abort = 1'b0;
      if (cyc == 0 || (glitch && obs_lat < 0 && cyc % 5 == 2)) begin
        mode = 2'($urandom); x_start = XB'($urandom); x_end = XB'($urandom);
        y_start = YB'($urandom); y_end = YB'($urandom); color = CB'($urandom);
        start = glitch;
      end
      if (aborted_at >= 0 && cyc == aborted_at + 1) begin
        ab_pe = print_enable; ab_busy = busy; ab_done = done; ab_cnt = int'(written_count);
      end
      if (done === 1'b1) begin
        if (obs_lat < 0) obs_lat = cyc;
        obs_done_w++;
      end
      if (busy !== (obs_lat < 0 && (aborted_at < 0 || cyc <= aborted_at))) obs_busy_bad++;
      if (print_enable === 1'b1) begin
        if (!prev_pe) begin
          obs_x.push_back(int'(paint_x_co));
          obs_y.push_back(int'(paint_y_co));
          obs_c.push_back(int'(color_output));
          run = 1; cx = int'(paint_x_co); cy = int'(paint_y_co);
          if (abort_wr > 0 && obs_x.size() == abort_wr) begin
            abort = 1'b1;
            aborted_at = cyc;
          end
        end else begin
          run++;
          if (int'(paint_x_co) != cx || int'(paint_y_co) != cy) obs_stable_bad++;
        end
      end else if (prev_pe) begin
        obs_len.push_back(run);
      end
      prev_pe = (print_enable === 1'b1);
      if (obs_lat >= 0 && cyc >= obs_lat + 2) break;
      if (aborted_at >= 0 && cyc >= aborted_at + 8) break;
    end
    start = 1'b0;
    abort = 1'b0;
    obs_timeout = (obs_lat < 0 && aborted_at < 0) ? 1 : 0;
    obs_cnt = int'(written_count);
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(posedge Clck);
    @(negedge Clck);
    vectors++; if (paint_x_co !== '0) begin miscompares++; $display("FAIL reset_x: got %0h expected 0", paint_x_co); end
    vectors++; if (paint_y_co !== '0) begin miscompares++; $display("FAIL reset_y: got %0h expected 0", paint_y_co); end
    vectors++; if (color_output !== '0) begin miscompares++; $display("FAIL reset_color: got %0h expected 0", color_output); end
    vectors++; if (print_enable !== 1'b0) begin miscompares++; $display("FAIL reset_pe: got %b expected 0", print_enable); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (written_count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", written_count); end
    Reset = 1'b1;
  endtask

  // k_cnt / k_lat are hand-derived figures for directed cases; -1 skips them.
  task automatic test_shape(input string nm, input int md, input int xs, input int xe, input int ys,
                            input int ye, input int col, input int k_cnt, input int k_lat);
    model_job(md, xs, xe, ys, ye);
    exec_job(md, xs, xe, ys, ye, col, 0);
    vectors++; if (obs_timeout != 0) begin miscompares++; $display("FAIL %s_timeout: got no done, expected done within budget", nm); end
    vectors++; if (obs_x.size() != exp_x.size()) begin miscompares++; $display("FAIL %s_nwrites: got %0d expected %0d", nm, obs_x.size(), exp_x.size()); end
    for (int i = 0; i < obs_x.size() && i < exp_x.size(); i++) begin
      vectors++;
      if (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i] || obs_c[i] != col) begin
        miscompares++;
        $display("FAIL %s_write%0d: got (%0d,%0d) c%0d expected (%0d,%0d) c%0d", nm, i, obs_x[i], obs_y[i], obs_c[i], exp_x[i], exp_y[i], col);
      end
    end
    for (int i = 0; i < obs_len.size(); i++) begin
      vectors++; if (obs_len[i] != H) begin miscompares++; $display("FAIL %s_strobe%0d: got %0d cycles expected %0d", nm, i, obs_len[i], H); end
    end
    vectors++; if (obs_cnt != exp_x.size()) begin miscompares++; $display("FAIL %s_count: got %0d expected %0d", nm, obs_cnt, exp_x.size()); end
    vectors++; if (obs_lat != exp_lat) begin miscompares++; $display("FAIL %s_latency: got %0d expected %0d", nm, obs_lat, exp_lat); end
    vectors++; if (obs_done_w != 1) begin miscompares++; $display("FAIL %s_done_width: got %0d expected 1", nm, obs_done_w); end
    vectors++; if (obs_busy_bad != 0) begin miscompares++; $display("FAIL %s_busy: got %0d bad cycles expected 0", nm, obs_busy_bad); end
    vectors++; if (obs_stable_bad != 0) begin miscompares++; $display("FAIL %s_stable: got %0d moving cycles expected 0", nm, obs_stable_bad); end
    if (k_cnt >= 0) begin
      vectors++; if (obs_cnt != k_cnt) begin miscompares++; $display("FAIL %s_count_plan: got %0d expected %0d", nm, obs_cnt, k_cnt); end
    end
    if (k_lat >= 0) begin
      vectors++; if (obs_lat != k_lat) begin miscompares++; $display("FAIL %s_latency_plan: got %0d expected %0d", nm, obs_lat, k_lat); end
    end
  endtask

  task automatic test_empty();
    exec_job(0, 7, 7, 0, 5, 2, 0);
    vectors++; if (obs_timeout != 0) begin miscompares++; $display("FAIL empty_timeout: got no done, expected done"); end
    vectors++; if (obs_x.size() != 0) begin miscompares++; $display("FAIL empty_writes: got %0d expected 0", obs_x.size()); end
    vectors++; if (obs_lat != 0) begin miscompares++; $display("FAIL empty_latency: got %0d expected 0", obs_lat); end
    vectors++; if (obs_cnt != 0) begin miscompares++; $display("FAIL empty_count: got %0d expected 0", obs_cnt); end
    vectors++; if (obs_done_w != 1) begin miscompares++; $display("FAIL empty_done_width: got %0d expected 1", obs_done_w); end
  endtask

  task automatic test_abort();
    exec_job(0, 2, 5, 3, 5, 6, 2);
    vectors++; if (obs_x.size() != 2) begin miscompares++; $display("FAIL abort_writes: got %0d expected 2", obs_x.size()); end
    vectors++; if (ab_pe != 0) begin miscompares++; $display("FAIL abort_pe: got %0d expected 0", ab_pe); end
    vectors++; if (ab_busy != 0) begin miscompares++; $display("FAIL abort_busy: got %0d expected 0", ab_busy); end
    vectors++; if (ab_done != 0) begin miscompares++; $display("FAIL abort_done_now: got %0d expected 0", ab_done); end
    vectors++; if (ab_cnt != 2) begin miscompares++; $display("FAIL abort_count: got %0d expected 2", ab_cnt); end
    vectors++; if (obs_done_w != 0) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses expected 0", obs_done_w); end
    vectors++; if (obs_cnt != 2) begin miscompares++; $display("FAIL abort_count_held: got %0d expected 2", obs_cnt); end
    test_shape("after_abort", 0, 2, 5, 3, 5, 6, 6, 42);
  endtask

  task automatic test_start_ignore();
    glitch = 1'b1;
    test_shape("start_ignore", 2, 0, 4, 0, 4, 5, 12, 92);
    glitch = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    @(negedge Clck);
    mode = 2'b00; x_start = 8'd2; x_end = 8'd5; y_start = 7'd3; y_end = 7'd5; color = 3'b110; start = 1'b1;
    @(posedge Clck);
    @(negedge Clck);
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (print_enable === 1'b1) begin seen = 1'b1; break; end
      @(negedge Clck);
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL rstmid_write: got no strobe expected strobe"); end
    Reset = 1'b0;
    @(posedge Clck);
    #1;
    vectors++; if (print_enable !== 1'b0) begin miscompares++; $display("FAIL rstmid_pe: got %b expected 0", print_enable); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done: got %b expected 0", done); end
    vectors++; if (paint_x_co !== '0 || paint_y_co !== '0) begin miscompares++; $display("FAIL rstmid_xy: got (%0d,%0d) expected (0,0)", paint_x_co, paint_y_co); end
    vectors++; if (color_output !== '0) begin miscompares++; $display("FAIL rstmid_color: got %0d expected 0", color_output); end
    vectors++; if (written_count !== '0) begin miscompares++; $display("FAIL rstmid_count: got %0d expected 0", written_count); end
    Reset = 1'b1;
    repeat (2) @(negedge Clck);
    vectors++; if (busy !== 1'b0 || print_enable !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle: got busy %b pe %b expected 0 0", busy, print_enable); end
  endtask

  task automatic test_random();
    int md, xs, xe, ys, ye;
    test_shape("max_corner", 2, 249, 255, 121, 127, 7, -1, -1);
    for (int n = 0; n < 20; n++) begin
      md = $urandom_range(0, 3);
      xs = $urandom_range(0, 250);
      xe = xs + $urandom_range(0, 6);
      if (xe > 255) xe = 255;
      ys = $urandom_range(0, 121);
      ye = ys + $urandom_range(0, 6);
      if (ye > 127) ye = 127;
      if ($urandom_range(0, 9) == 0) xe = $urandom_range(0, xs);
      test_shape("random", md, xs, xe, ys, ye, $urandom_range(0, 7), -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_shape("rect", 0, 2, 5, 3, 5, 6, 6, 42);
    test_shape("circle", 2, 0, 4, 0, 4, 3, 12, 92);
    test_shape("border", 1, 10, 14, 20, 23, 1, 10, 74);
    test_shape("mode3", 3, 30, 33, 40, 42, 4, 6, 42);
    test_empty();
    test_abort();
    test_start_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
